// File: rtl/display_page_scheduler.sv
// Snapshots the vending values, converts money to two BCD digits with a serial shift-add-3
// engine and assembles an 8-digit page; a timed alert page can pre-empt it. Macro: LEADING_BLANK_EN.
module display_page_scheduler #(
  parameter int unsigned ALERT_CYCLES   = 50_000_000,
  parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [5:0]  state,
  input  logic [6:0]  need_money,
  input  logic [7:0]  input_money,
  input  logic [7:0]  change_money,
  input  logic [2:0]  in_goods_high,
  input  logic [2:0]  in_goods_low,
  input  logic [1:0]  in_goods_num,
  input  logic        alert_req,
  input  logic [3:0]  alert_code,
  output logic [39:0] digit_codes,
  output logic        frame_valid,
  output logic [1:0]  page_id,
  output logic        busy,
  output logic        overflow
);
  localparam int unsigned TW = $clog2(ALERT_CYCLES + 1);
  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [4:0]  BLANK = 5'd16;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_CONV, S_COMMIT} fsm_e;

  typedef struct packed {
    logic [5:0] st;
    logic [7:0] need;
    logic [7:0] inm;
    logic [7:0] chg;
    logic [2:0] gh;
    logic [2:0] gl;
    logic [1:0] gn;
  } bundle_t;

  fsm_e            fsm_q, fsm_d;
  bundle_t         live, snap_q;
  logic            pending_q, pending_d;
  logic [RW-1:0]   rcnt_q;
  logic            rhit, trig, commit;
  logic [7:0]      sh_q;
  logic [11:0]     bcd_q, bcd_adj, bcd_nx;
  logic [2:0]      bit_q;
  logic [1:0]      idx_q;
  logic [2:0][7:0] res_q;
  logic [2:0]      ovfv_q;
  logic [7:0]      res_nx;
  logic            ovf_nx;
  logic [7:0][4:0] page_d, shadow_q, dc_q, alert_pg;
  logic [1:0]      psel, spage_q, pid_q;
  logic            fv_q, ovf_q;
  logic [TW-1:0]   timer_q;

  assign live = '{st: state, need: {1'b0, need_money}, inm: input_money, chg: change_money,
                  gh: in_goods_high, gl: in_goods_low, gn: in_goods_num};
  assign rhit = (rcnt_q == RW'(REFRESH_CYCLES - 1));
  assign trig = (live != snap_q) || rhit;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)   rcnt_q <= '0;
    else if (rhit) rcnt_q <= '0;
    else           rcnt_q <= rcnt_q + RW'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fsm_q     <= S_IDLE;
      pending_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      pending_q <= pending_d;
    end
  end

  // Conversion always runs 3x8 cycles, so the frame latency is fixed whatever the page.
  always_comb begin
    fsm_d     = fsm_q;
    pending_d = pending_q;
    commit    = 1'b0;
    unique case (fsm_q)
      S_IDLE:   if (trig) fsm_d = S_LATCH;
      S_LATCH: begin
        fsm_d     = S_CONV;
        pending_d = rhit;
      end
      S_CONV: begin
        pending_d = pending_q | trig;
        if (bit_q == 3'd7 && idx_q == 2'd2) fsm_d = S_COMMIT;
      end
      S_COMMIT: begin
        commit    = 1'b1;
        pending_d = 1'b0;
        fsm_d     = (pending_q || trig) ? S_LATCH : S_IDLE;
      end
      default:  fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    bcd_nx = {bcd_adj[10:0], sh_q[7]};
    ovf_nx = (bcd_nx[11:8] != 4'd0);
    res_nx = ovf_nx ? 8'h99 : bcd_nx[7:0];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      snap_q <= '0;
      sh_q   <= '0;
      bcd_q  <= '0;
      bit_q  <= '0;
      idx_q  <= '0;
      res_q  <= '0;
      ovfv_q <= '0;
    end else begin
      case (fsm_q)
        S_LATCH: begin
          snap_q <= live;
          sh_q   <= live.need;
          bcd_q  <= '0;
          bit_q  <= '0;
          idx_q  <= '0;
        end
        S_CONV: begin
          bcd_q <= bcd_nx;
          sh_q  <= {sh_q[6:0], 1'b0};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            case (idx_q)
              2'd0:    begin res_q[0] <= res_nx; ovfv_q[0] <= ovf_nx; end
              2'd1:    begin res_q[1] <= res_nx; ovfv_q[1] <= ovf_nx; end
              default: begin res_q[2] <= res_nx; ovfv_q[2] <= ovf_nx; end
            endcase
            bcd_q <= '0;
            idx_q <= idx_q + 2'd1;
            sh_q  <= (idx_q == 2'd0) ? snap_q.inm : snap_q.chg;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [4:0] tens_glyph(input logic [3:0] t);
`ifdef LEADING_BLANK_EN
    return (t == 4'd0) ? BLANK : {1'b0, t};
`else
    return {1'b0, t};
`endif
  endfunction

  always_comb begin
    page_d = {8{BLANK}};
    psel   = 2'd0;
    case (snap_q.st)
      6'b000001, 6'b001000, 6'b010000, 6'b100000: begin
        psel      = 2'd1;
        page_d[0] = {1'b0, res_q[0][3:0]};
        page_d[1] = tens_glyph(res_q[0][7:4]);
        page_d[3] = {1'b0, res_q[1][3:0]};
        page_d[4] = tens_glyph(res_q[1][7:4]);
        page_d[6] = {1'b0, res_q[2][3:0]};
        page_d[7] = tens_glyph(res_q[2][7:4]);
      end
      6'b000010, 6'b000100: begin
        psel      = 2'd2;
        page_d[0] = {3'b0, snap_q.gn};
        page_d[5] = {2'b0, snap_q.gl};
        page_d[6] = {2'b0, snap_q.gh};
        page_d[7] = 5'd10;
      end
      default: ;
    endcase
  end

  always_comb begin
    alert_pg    = {8{BLANK}};
    alert_pg[7] = 5'd14;
    alert_pg[0] = {1'b0, alert_code};
  end

  // Priority: new alert, then expiry (shows the freshest shadow), then hold, then normal commit.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shadow_q <= {8{BLANK}};
      spage_q  <= 2'd0;
      dc_q     <= {8{BLANK}};
      pid_q    <= 2'd0;
      fv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      fv_q <= 1'b0;
      if (commit) begin
        shadow_q <= page_d;
        spage_q  <= psel;
        ovf_q    <= |ovfv_q;
      end
      if (alert_req) begin
        timer_q <= TW'(ALERT_CYCLES);
        dc_q    <= alert_pg;
        pid_q   <= 2'd3;
        fv_q    <= 1'b1;
      end else if (timer_q == TW'(1)) begin
        timer_q <= '0;
        dc_q    <= commit ? page_d : shadow_q;
        pid_q   <= commit ? psel : spage_q;
        fv_q    <= 1'b1;
      end else if (timer_q != '0) begin
        timer_q <= timer_q - TW'(1);
      end else if (commit) begin
        dc_q  <= page_d;
        pid_q <= psel;
        fv_q  <= 1'b1;
      end
    end
  end

  assign digit_codes = dc_q;
  assign frame_valid = fv_q;
  assign page_id     = pid_q;
  assign busy        = (fsm_q != S_IDLE);
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_display_page_scheduler.sv
// Bench for display_page_scheduler: a timestamp-based behavioural model checks every output each
// cycle under directed and randomized stimulus, plus explicit checks of the documented scenarios.
module tb_display_page_scheduler;
  localparam int AC = 100;
  localparam int RC = 2000;
`ifdef LEADING_BLANK_EN
  localparam logic [4:0] ZT = 5'd16;
`else
  localparam logic [4:0] ZT = 5'd0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [5:0]  state;
  logic [6:0]  need_money;
  logic [7:0]  input_money, change_money;
  logic [2:0]  in_goods_high, in_goods_low;
  logic [1:0]  in_goods_num;
  logic        alert_req;
  logic [3:0]  alert_code;
  logic [39:0] digit_codes;
  logic        frame_valid, busy, overflow;
  logic [1:0]  page_id;

  always #5 sys_clk = ~sys_clk;

  display_page_scheduler #(.ALERT_CYCLES(AC), .REFRESH_CYCLES(RC)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .state(state), .need_money(need_money),
    .input_money(input_money), .change_money(change_money), .in_goods_high(in_goods_high),
    .in_goods_low(in_goods_low), .in_goods_num(in_goods_num), .alert_req(alert_req),
    .alert_code(alert_code), .digit_codes(digit_codes), .frame_valid(frame_valid),
    .page_id(page_id), .busy(busy), .overflow(overflow));

  int n_tests = 0, n_fail = 0;
  int gc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, gc);
    end
  endtask

  // ---------------- reference model ----------------
  int          rk, phase, alert_end;
  bit          pending;
  logic [36:0] snap;
  logic [39:0] m_shadow, e_dc;
  logic [1:0]  m_spage, e_pid;
  bit          e_fv, e_ovf, e_busy;

  function automatic logic [4:0] ones_d(int v);
    return (v > 99) ? 5'd9 : 5'(v % 10);
  endfunction

  function automatic logic [4:0] tens_d(int v);
    if (v > 99) return 5'd9;
    if (v / 10 == 0) return ZT;
    return 5'(v / 10);
  endfunction

  function automatic logic [39:0] all_blank();
    logic [7:0][4:0] p;
    for (int k = 0; k < 8; k++) p[k] = 5'd16;
    return p;
  endfunction

  function automatic logic [39:0] alert_page(int code);
    logic [7:0][4:0] p;
    p = all_blank();
    p[7] = 5'd14;
    p[0] = 5'(code);
    return p;
  endfunction

  task automatic page_of(input logic [36:0] s, output logic [39:0] pg, output logic [1:0] id,
                         output bit ov);
    logic [7:0][4:0] p;
    int n, i, c;
    n = int'(s[30:24]); i = int'(s[23:16]); c = int'(s[15:8]);
    ov = (n > 99) || (i > 99) || (c > 99);
    p = all_blank();
    id = 2'd0;
    case (s[36:31])
      6'b000001, 6'b001000, 6'b010000, 6'b100000: begin
        id = 2'd1;
        p[0] = ones_d(n); p[1] = tens_d(n);
        p[3] = ones_d(i); p[4] = tens_d(i);
        p[6] = ones_d(c); p[7] = tens_d(c);
      end
      6'b000010, 6'b000100: begin
        id = 2'd2;
        p[0] = 5'(s[1:0]); p[5] = 5'(s[4:2]); p[6] = 5'(s[7:5]); p[7] = 5'd10;
      end
      default: ;
    endcase
    pg = p;
  endtask

  // phase: -1 idle, 0 latch, 1..24 converting, 25 commit
  task automatic model_step();
    logic [36:0] live;
    bit hit, diff, commit;
    int nph;
    logic [39:0] pg;
    logic [1:0] id;
    bit ov;
    if (sys_rst) begin
      rk = 0; phase = -1; pending = 0; snap = '0; alert_end = -1;
      m_shadow = all_blank(); m_spage = 0;
      e_dc = all_blank(); e_pid = 0; e_fv = 0; e_ovf = 0; e_busy = 0;
      gc++;
      return;
    end
    live = {state, need_money, input_money, change_money, in_goods_high, in_goods_low, in_goods_num};
    hit  = (rk % RC) == RC - 1;
    rk++;
    diff = (live != snap);
    commit = 0;
    if (phase < 0) nph = (diff || hit) ? 0 : -1;
    else if (phase == 0) begin snap = live; pending = hit; nph = 1; end
    else if (phase < 25) begin pending = pending || diff || hit; nph = phase + 1; end
    else begin
      commit = 1;
      page_of(snap, pg, id, ov);
      m_shadow = pg; m_spage = id; e_ovf = ov;
      nph = (pending || diff || hit) ? 0 : -1;
      pending = 0;
    end
    phase = nph;
    e_busy = (nph >= 0);
    e_fv = 0;
    if (alert_req) begin
      alert_end = gc + AC;
      e_dc = alert_page(int'(alert_code)); e_pid = 3; e_fv = 1;
    end else if (gc == alert_end) begin
      e_dc = m_shadow; e_pid = m_spage; e_fv = 1;
    end else if (gc < alert_end) begin
      // alert page held
    end else if (commit) begin
      e_dc = m_shadow; e_pid = m_spage; e_fv = 1;
    end
    gc++;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    chk("digits", digit_codes, e_dc);
    chk("page_id", page_id, e_pid);
    chk("frame_valid", frame_valid, e_fv);
    chk("overflow", overflow, e_ovf);
    chk("busy", busy, e_busy);
  endtask

  task automatic wait_frame(input string tag, input int bound, output int n);
    n = 0;
    do begin tick(); n++; end while (!frame_valid && n < bound);
    chk(tag, frame_valid, 1'b1);
  endtask

  logic [5:0] st_tab [8] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                             6'b010000, 6'b100000, 6'b000011, 6'b000000};

  initial begin
    int n, idle_seen;
    logic [39:0] exp_pg;
    sys_rst = 1'b1; state = '0; need_money = '0; input_money = '0; change_money = '0;
    in_goods_high = '0; in_goods_low = '0; in_goods_num = '0; alert_req = 1'b0; alert_code = '0;
    @(negedge sys_clk);
    repeat (3) tick();
    chk("rst_digits", digit_codes, all_blank());
    chk("rst_page", page_id, 2'd0);
    sys_rst = 1'b0;

    // Money page, latency
    state = 6'b000001; need_money = 7'd15;
    tick();
    wait_frame("t1_frame", 60, n);
    chk("t1_latency", n, 26);
    chk("t1_d1d0", digit_codes[9:0], {5'd1, 5'd5});
    chk("t1_d2", digit_codes[14:10], 5'd16);
    chk("t1_d4d3", digit_codes[24:15], {ZT, 5'd0});
    chk("t1_pid", page_id, 2'd1);

    // Idle change of input money
    input_money = 8'd20;
    wait_frame("t2_frame", 60, n);
    chk("t2_latency", n, 27);
    chk("t2_d4d3", digit_codes[24:15], {5'd2, 5'd0});
    repeat (5) tick();

    // Change during conversion: two frames, no idle gap
    need_money = 7'd40;
    repeat (12) tick();
    need_money = 7'd77;
    wait_frame("t3_f1", 60, n);
    chk("t3_f1_d1d0", digit_codes[9:0], {5'd4, 5'd0});
    idle_seen = 0;
    n = 0;
    do begin tick(); n++; if (!busy && !frame_valid) idle_seen++; end
    while (!frame_valid && n < 60);
    chk("t3_f2", frame_valid, 1'b1);
    chk("t3_no_idle", idle_seen, 0);
    chk("t3_f2_d1d0", digit_codes[9:0], {5'd7, 5'd7});

    // Saturation and overflow
    repeat (3) tick();
    input_money = 8'd150;
    wait_frame("t4_f1", 60, n);
    chk("t4_d4d3", digit_codes[24:15], {5'd9, 5'd9});
    chk("t4_ovf1", overflow, 1'b1);
    input_money = 8'd30;
    wait_frame("t4_f2", 60, n);
    chk("t4_ovf0", overflow, 1'b0);
    chk("t4_d4d3b", digit_codes[24:15], {5'd3, 5'd0});

    // Goods page
    state = 6'b000010; in_goods_high = 3'd3; in_goods_low = 3'd2; in_goods_num = 2'd1;
    wait_frame("t5_frame", 60, n);
    exp_pg = {5'd10, 5'd3, 5'd2, 5'd16, 5'd16, 5'd16, 5'd16, 5'd1};
    chk("t5_digits", digit_codes, exp_pg);
    chk("t5_pid", page_id, 2'd2);

    // Alert pre-emption with money change underneath
    state = 6'b000001; need_money = 7'd15; change_money = 8'd0;
    wait_frame("t6_pre", 60, n);
    alert_req = 1'b1; alert_code = 4'd5;
    tick();
    alert_req = 1'b0;
    chk("t6_pid", page_id, 2'd3);
    chk("t6_digits", digit_codes, alert_page(5));
    chk("t6_fv", frame_valid, 1'b1);
    repeat (9) tick();
    need_money = 7'd5;
    wait_frame("t6_restore", 120, n);
    chk("t6_hold", n, 91);
    chk("t6_pid_back", page_id, 2'd1);
    chk("t6_d1d0", digit_codes[9:0], {ZT, 5'd5});

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      alert_req = ($urandom_range(0, 399) == 0);
      alert_code = 4'($urandom);
      sys_rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 4))
          0: state = st_tab[$urandom_range(0, 7)];
          1: need_money = 7'($urandom_range(0, 127));
          2: input_money = 8'($urandom_range(0, 255));
          3: change_money = 8'($urandom_range(0, 120));
          default: begin
            in_goods_high = 3'($urandom); in_goods_low = 3'($urandom); in_goods_num = 2'($urandom);
          end
        endcase
      end
      tick();
    end
    sys_rst = 1'b0; alert_req = 1'b0;
    repeat (150) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
